// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/hazard_controller_forward_select.sv
// Operand bypass select for one execute source register.
module forward_select
  import hazard_pkg::*;
(
  input  logic [3:0] ra_e,
  input  logic [3:0] wa3_m,
  input  logic       reg_write_m,
  input  logic [3:0] wa3_w,
  input  logic       reg_write_w,
  output fwd_sel_t   sel
);

  logic not_pc;

  assign not_pc = (ra_e != PC_REG);

  // The younger result in M shadows the one in W.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (wa3_m == ra_e) && not_pc) begin
      sel = FWD_M;
    end else if (reg_write_w && (wa3_w == ra_e) && not_pc) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Stall, flush and forwarding control around decode and the D/E register.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int STUCK_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       RA1H,
  input  logic [3:0]       RA2H,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [3:0]       WA3M,
  input  logic             RegWriteM,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteW,
  input  logic             PCSrcD,
  input  logic             BranchTakenE,
  input  logic             Stuck,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCount
);

  localparam int CW = (STUCK_CYCLES > 2) ? $clog2(STUCK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STUCK_CYCLES - 2);

  hz_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_e_q, pend_e_d;
  logic             pend_m_q, pend_m_d;
  logic             pend_w_q, pend_w_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic     ldstall;
  logic     pending;
  logic     enter;
  logic     busy;
  logic     stall_f;
  logic     stall_d;
  logic     flush_d;
  logic     flush_e;
  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  forward_select u_fwd_a (
    .ra_e        (RA1E),
    .wa3_m       (WA3M),
    .reg_write_m (RegWriteM),
    .wa3_w       (WA3W),
    .reg_write_w (RegWriteW),
    .sel         (fwd_a)
  );

  forward_select u_fwd_b (
    .ra_e        (RA2E),
    .wa3_m       (WA3M),
    .reg_write_m (RegWriteM),
    .wa3_w       (WA3W),
    .reg_write_w (RegWriteW),
    .sel         (fwd_b)
  );

  always_comb begin
    ldstall = MemtoRegE & RegWriteE
            & ((RA1H == WA3E) | (RA2H == WA3E))
            & (state_q == RUN);
    pending = PCSrcD | pend_e_q | pend_m_q;
    enter   = (state_q == RUN) & Stuck & ~ldstall
            & ~BranchTakenE & ~pending;
    busy    = enter | ((state_q == HOLD) & (cnt_q != '0));
    stall_f = ldstall | pending | busy;
    stall_d = ldstall | busy;
    flush_d = pending | pend_w_q | BranchTakenE;
    flush_e = ldstall | BranchTakenE | busy;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (enter) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      HOLD: begin
        // A taken branch squashes the held instruction outright.
        if (BranchTakenE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pend_e_d = PCSrcD & ~flush_e;
    pend_m_d = pend_e_q & ~BranchTakenE;
    pend_w_d = pend_m_q;
    scnt_d   = scnt_q;
    if (stall_d && (scnt_q != '1)) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      pend_e_q <= 1'b0;
      pend_m_q <= 1'b0;
      pend_w_q <= 1'b0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_e_q <= pend_e_d;
      pend_m_q <= pend_m_d;
      pend_w_q <= pend_w_d;
      scnt_q   <= scnt_d;
    end
  end

  // Controls are forced quiet while reset is held.
  always_comb begin
    StallF    = stall_f & ~rst;
    StallD    = stall_d & ~rst;
    FlushD    = flush_d & ~rst;
    FlushE    = flush_e & ~rst;
    ForwardAE = rst ? FWD_RF : fwd_a;
    ForwardBE = rst ? FWD_RF : fwd_b;
  end

  assign StallCount = scnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: vector table plus sequences.
module tb_hazard_controller;

  localparam int SC = 4;
  localparam int CW = 4;
  localparam logic [CW-1:0] MAXC = '1;

  typedef struct packed {
    logic       rst;
    logic [3:0] ra1h;
    logic [3:0] ra2h;
    logic [3:0] ra1e;
    logic [3:0] ra2e;
    logic [3:0] wa3e;
    logic       rwe;
    logic       m2re;
    logic [3:0] wa3m;
    logic       rwm;
    logic [3:0] wa3w;
    logic       rww;
    logic       pcs;
    logic       bte;
    logic       stuck;
  } in_t;

  typedef struct {
    string         nm;
    logic          sf;
    logic          sd;
    logic          fd;
    logic          fe;
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    in_t        in;
    string      nm;
    logic [3:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    RA1H = '0, RA2H = '0, RA1E = '0, RA2E = '0;
  logic [3:0]    WA3E = '0, WA3M = '0, WA3W = '0;
  logic          RegWriteE = 0, MemtoRegE = 0;
  logic          RegWriteM = 0, RegWriteW = 0;
  logic          PCSrcD = 0, BranchTakenE = 0, Stuck = 0;
  logic          StallF, StallD, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] mcnt = '0;
  exp_t          sb[$];
  exp_t          ce;
  vec_t          tbl[$];

  always #5 clk = ~clk;

  hazard_controller #(
    .STUCK_CYCLES (SC),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RA1H         (RA1H),
    .RA2H         (RA2H),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .RegWriteE    (RegWriteE),
    .MemtoRegE    (MemtoRegE),
    .WA3M         (WA3M),
    .RegWriteM    (RegWriteM),
    .WA3W         (WA3W),
    .RegWriteW    (RegWriteW),
    .PCSrcD       (PCSrcD),
    .BranchTakenE (BranchTakenE),
    .Stuck        (Stuck),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallCount   (StallCount)
  );

  // Outputs are sampled mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      n_tests++;
      if ({StallF, StallD, FlushD, FlushE} !== {ce.sf, ce.sd, ce.fd, ce.fe}
          || ForwardAE !== ce.fa || ForwardBE !== ce.fb
          || StallCount !== ce.cnt) begin
        n_fail++;
        $display("FAIL %s: got sf/sd/fd/fe=%b%b%b%b fa=%b fb=%b cnt=%0d, exp %b%b%b%b fa=%b fb=%b cnt=%0d",
                 ce.nm, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
                 StallCount, ce.sf, ce.sd, ce.fd, ce.fe, ce.fa, ce.fb, ce.cnt);
      end
    end
  end

  task automatic ap(input in_t i, input string nm,
                    input logic [3:0] ctl,
                    input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = i.rst;
    RA1H         = i.ra1h;
    RA2H         = i.ra2h;
    RA1E         = i.ra1e;
    RA2E         = i.ra2e;
    WA3E         = i.wa3e;
    RegWriteE    = i.rwe;
    MemtoRegE    = i.m2re;
    WA3M         = i.wa3m;
    RegWriteM    = i.rwm;
    WA3W         = i.wa3w;
    RegWriteW    = i.rww;
    PCSrcD       = i.pcs;
    BranchTakenE = i.bte;
    Stuck        = i.stuck;
    e.nm  = nm;
    e.sf  = ctl[3];
    e.sd  = ctl[2];
    e.fd  = ctl[1];
    e.fe  = ctl[0];
    e.fa  = fa;
    e.fb  = fb;
    e.cnt = mcnt;
    sb.push_back(e);
    if (i.rst) mcnt = '0;
    else if (ctl[2] && mcnt != MAXC) mcnt = mcnt + 1'b1;
  endtask

  task automatic add(input in_t i, input string nm, input logic [3:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.in  = i;
    v.nm  = nm;
    v.ctl = ctl;
    v.fa  = fa;
    v.fb  = fb;
    tbl.push_back(v);
  endtask

  // ctl bit order: StallF, StallD, FlushD, FlushE
  initial begin
    in_t i;
    in_t z;
    z = '0;

    i = z; i.rst = 1; i.rwm = 1; i.wa3m = 3; i.ra1e = 3;
    add(i, "reset_quiet", 4'b0000, 2'b00, 2'b00);
    i = z; i.rst = 1; i.pcs = 1; i.m2re = 1; i.rwe = 1;
    add(i, "reset_gate", 4'b0000, 2'b00, 2'b00);
    i = z; i.rwm = 1; i.wa3m = 3; i.rww = 1; i.wa3w = 3; i.ra1e = 3;
    add(i, "fwdA_M_over_W", 4'b0000, 2'b10, 2'b00);
    i.rwm = 0;
    add(i, "fwdA_W", 4'b0000, 2'b01, 2'b00);
    i.rwm = 1; i.ra1e = 15; i.wa3m = 15; i.wa3w = 15;
    add(i, "fwdA_pc", 4'b0000, 2'b00, 2'b00);
    i = z; i.rwm = 1; i.wa3m = 7; i.ra2e = 7;
    add(i, "fwdB_M", 4'b0000, 2'b00, 2'b10);
    i = z; i.rww = 1; i.wa3w = 7; i.wa3m = 7; i.ra2e = 7;
    add(i, "fwdB_W", 4'b0000, 2'b00, 2'b01);
    i = z; i.rwm = 1; i.wa3m = 2; i.rww = 1; i.wa3w = 2;
    i.ra1e = 2; i.ra2e = 2;
    add(i, "fwd_both_M", 4'b0000, 2'b10, 2'b10);
    i = z; i.rwm = 1; i.wa3m = 4; i.rww = 1; i.wa3w = 9;
    i.ra1e = 4; i.ra2e = 9;
    add(i, "fwd_mix", 4'b0000, 2'b10, 2'b01);
    i = z; i.wa3m = 3; i.wa3w = 3; i.ra1e = 3;
    add(i, "fwd_nowrite", 4'b0000, 2'b00, 2'b00);
    i = z; i.rww = 1; i.wa3w = 15; i.ra2e = 15;
    add(i, "fwdB_pc", 4'b0000, 2'b00, 2'b00);
    i = z; i.m2re = 1; i.rwe = 1; i.wa3e = 5; i.ra2h = 5; i.ra1h = 1;
    add(i, "lduse", 4'b1101, 2'b00, 2'b00);
    add(z, "lduse_after", 4'b0000, 2'b00, 2'b00);
    i = z; i.m2re = 1; i.rwe = 0; i.wa3e = 5; i.ra1h = 5;
    add(i, "ld_nowrite", 4'b0000, 2'b00, 2'b00);
    i = z; i.m2re = 0; i.rwe = 1; i.wa3e = 5; i.ra1h = 5;
    add(i, "alu_no_stall", 4'b0000, 2'b00, 2'b00);

    foreach (tbl[k]) ap(tbl[k].in, tbl[k].nm, tbl[k].ctl, tbl[k].fa, tbl[k].fb);

    // PC write drains through E and M, then W flushes D once more
    i = z; i.pcs = 1;
    ap(i, "br_d", 4'b1010, 2'b00, 2'b00);
    ap(z, "br_e", 4'b1010, 2'b00, 2'b00);
    ap(z, "br_m", 4'b1010, 2'b00, 2'b00);
    ap(z, "br_w", 4'b0010, 2'b00, 2'b00);
    ap(z, "br_done", 4'b0000, 2'b00, 2'b00);

    i = z; i.stuck = 1;
    ap(i, "stuck_1", 4'b1101, 2'b00, 2'b00);
    ap(i, "stuck_2", 4'b1101, 2'b00, 2'b00);
    ap(i, "stuck_3", 4'b1101, 2'b00, 2'b00);
    ap(i, "stuck_last", 4'b0000, 2'b00, 2'b00);
    ap(z, "stuck_done", 4'b0000, 2'b00, 2'b00);

    i = z; i.stuck = 1;
    ap(i, "hbr_enter", 4'b1101, 2'b00, 2'b00);
    ap(i, "hbr_hold", 4'b1101, 2'b00, 2'b00);
    i.bte = 1;
    ap(i, "hbr_taken", 4'b1111, 2'b00, 2'b00);
    ap(z, "hbr_after", 4'b0000, 2'b00, 2'b00);

    i = z; i.stuck = 1; i.m2re = 1; i.rwe = 1; i.wa3e = 5; i.ra1h = 5;
    ap(i, "ld_stuck_bubble", 4'b1101, 2'b00, 2'b00);
    i.m2re = 0; i.rwe = 0;
    ap(i, "ld_stuck_enter", 4'b1101, 2'b00, 2'b00);
    ap(i, "ld_stuck_h2", 4'b1101, 2'b00, 2'b00);
    ap(i, "ld_stuck_h1", 4'b1101, 2'b00, 2'b00);
    ap(i, "ld_stuck_last", 4'b0000, 2'b00, 2'b00);

    i = z; i.stuck = 1; i.pcs = 1;
    ap(i, "pend_blk_d", 4'b1010, 2'b00, 2'b00);
    i.pcs = 0;
    ap(i, "pend_blk_e", 4'b1010, 2'b00, 2'b00);
    ap(i, "pend_blk_m", 4'b1010, 2'b00, 2'b00);
    ap(i, "pend_w_enter", 4'b1111, 2'b00, 2'b00);
    ap(i, "pend_h2", 4'b1101, 2'b00, 2'b00);
    ap(i, "pend_h1", 4'b1101, 2'b00, 2'b00);
    ap(i, "pend_last", 4'b0000, 2'b00, 2'b00);

    // Bubble in E kills the PC write from being tracked downstream
    i = z; i.pcs = 1; i.m2re = 1; i.rwe = 1; i.wa3e = 5; i.ra1h = 5;
    ap(i, "pcs_flushed", 4'b1111, 2'b00, 2'b00);
    ap(z, "pcs_flushed_gone", 4'b0000, 2'b00, 2'b00);

    i = z; i.stuck = 1;
    ap(i, "rh_enter", 4'b1101, 2'b00, 2'b00);
    ap(i, "rh_hold", 4'b1101, 2'b00, 2'b00);
    i.rst = 1;
    ap(i, "rh_reset", 4'b0000, 2'b00, 2'b00);
    ap(z, "rh_after", 4'b0000, 2'b00, 2'b00);

    i = z; i.pcs = 1;
    ap(i, "rp_d", 4'b1010, 2'b00, 2'b00);
    ap(z, "rp_e", 4'b1010, 2'b00, 2'b00);
    i = z; i.rst = 1;
    ap(i, "rp_reset", 4'b0000, 2'b00, 2'b00);
    ap(z, "rp_after", 4'b0000, 2'b00, 2'b00);

    i = z; i.m2re = 1; i.rwe = 1; i.wa3e = 6; i.ra1h = 6;
    for (int k = 0; k < 20; k++) begin
      ap(i, "sat_stall", 4'b1101, 2'b00, 2'b00);
    end
    ap(z, "sat_hold", 4'b0000, 2'b00, 2'b00);
    ap(z, "sat_hold2", 4'b0000, 2'b00, 2'b00);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline hazard and sequencing controller for the 5-stage (F/D/E/M/W) 24-bit core. It generates the stall, flush and forwarding controls around the decode stage and its D/E pipeline register (FlushE, RA1H/RA2H, RA1E/RA2E). It tracks in-flight PC writes, inserts load-use bubbles, and holds decode for multi-cycle instructions flagged by the control unit's Stuck. It also keeps a saturating stall-cycle performance counter.

Parameters:
STUCK_CYCLES, 4, total cycles a Stuck instruction occupies decode (>=2)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
RA1H  in  4  decode source reg 1
RA2H  in  4  decode source reg 2
RA1E  in  4  execute source reg 1
RA2E  in  4  execute source reg 2
WA3E  in  4  execute destination reg
RegWriteE  in  1  execute writes a register
MemtoRegE  in  1  execute instruction is a load
WA3M  in  4  memory-stage destination reg
RegWriteM  in  1  memory-stage register write
WA3W  in  4  writeback destination reg
RegWriteW  in  1  writeback register write
PCSrcD  in  1  decode instruction writes PC
BranchTakenE  in  1  branch resolved taken in execute
Stuck  in  1  decode instruction is multi-cycle
StallF  out  1  hold fetch PC register
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding
StallCount  out  CNT_W  cycles with StallD=1, saturating

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset clears the following: state=RUN, cnt=0, pend_e/pend_m/pend_w=0, StallCount=0.
- During rst, all control outputs are 0 and forwarding outputs are 00.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and WA3M==RA1E and RA1E!=4'hF.
  - Else ForwardAE=01 if RegWriteW and WA3W==RA1E and RA1E!=4'hF.
  - Else ForwardAE=00.
  - ForwardBE is identical using RA2E. M has priority over W.
- Load-use: ldstall = MemtoRegE & RegWriteE & (RA1H==WA3E | RA2H==WA3E) & state==RUN.
- PC-write tracking (shift register, one stage per cycle):
  - pend_e <= PCSrcD & ~FlushE
  - pend_m <= pend_e & ~BranchTakenE
  - pend_w <= pend_m
  - pending = PCSrcD | pend_e | pend_m
- FSM states: RUN, HOLD.
  - RUN -> HOLD when Stuck & ~ldstall & ~BranchTakenE & ~pending. Load cnt = STUCK_CYCLES-2.
  - HOLD, cnt!=0: cnt decrements.
  - HOLD, cnt==0: -> RUN.
  - HOLD and BranchTakenE: -> RUN immediately, cnt=0 (the stuck instruction is flushed).
  - busy = (state==RUN & Stuck & ~ldstall & ~BranchTakenE & ~pending) | (state==HOLD & ~(cnt==0)).
  - Total decode occupancy of a Stuck instruction = STUCK_CYCLES cycles.
- Outputs:
  - StallF = ldstall | pending | busy
  - StallD = ldstall | busy
  - FlushD = pending | pend_w | BranchTakenE
  - FlushE = ldstall | BranchTakenE | busy
- Simultaneous events:
  - Flush beats stall on the same register; the D/E register gives clr priority.
  - ldstall together with Stuck: the 1-cycle bubble comes first, then HOLD entry on the next cycle (the instruction is still in D).
- StallCount increments when StallD=1. It saturates at all-ones and never wraps.
- Reset mid-HOLD returns to RUN the next edge with all pending bits cleared.

Decomposition:
- Package hazard_pkg holds:
  - the typedef enum logic [0:0] {RUN, HOLD} hz_state_t;
  - fwd_sel_t constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - PC_REG=4'hF.
- One sub-module, forward_select: combinational, instantiated twice for the A and B operands.

Test Plan:
- Forwarding: RegWriteM=1, WA3M=3, RA1E=3, and RegWriteW=1, WA3W=3 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. RA1E=15 -> 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2H=5 -> one cycle with StallF=StallD=FlushE=1, next cycle all 0, StallCount=1.
- Branch drain: PCSrcD pulse for one cycle, no stalls -> StallF=1 for 3 cycles and FlushD=1 for 4 cycles, then both 0.
- Stuck with STUCK_CYCLES=4: Stuck held -> StallD=StallF=FlushE=1 for exactly 3 cycles, then 0, StallCount=3.
- BranchTakenE during HOLD: FSM returns to RUN, FlushD=FlushE=1 that cycle, StallD=0 the next.
- rst asserted mid-HOLD with pend_m=1 -> next cycle all outputs 0, StallCount=0.
